// File: rtl/spi_ram_ctrl.sv
// Command-driven single-port word memory fed by SPI slave opcode frames.
// Supports address auto-increment with wrap, tx backpressure and sticky error flags.
module spi_ram_ctrl #(
    parameter int MEM_DEPTH = 256,
    parameter int DATA_W    = 8,
    parameter int AUTO_INC  = 1,
    localparam int ADDR_W   = $clog2(MEM_DEPTH),
    localparam int PAY_W    = (ADDR_W > DATA_W) ? ADDR_W : DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [PAY_W+1:0]  rx_data,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic              err_clr,
    output logic              addr_err,
    output logic              overrun
);

    typedef enum logic [1:0] {
        OP_SET_WR = 2'b00,
        OP_WRITE  = 2'b01,
        OP_SET_RD = 2'b10,
        OP_READ   = 2'b11
    } op_e;

    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;

    op_e               op;
    logic [ADDR_W-1:0] pay_addr;
    logic [DATA_W-1:0] pay_data;
    logic              addr_ok;
    logic              wr_en;
    logic              rd_fire;
    logic              rd_drop;
    logic              set_err;

    function automatic logic [ADDR_W-1:0] bump(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

    always_comb begin
        op       = op_e'(rx_data[PAY_W+1:PAY_W]);
        pay_addr = rx_data[ADDR_W-1:0];
        pay_data = rx_data[DATA_W-1:0];
        addr_ok  = {1'b0, pay_addr} < DEPTH_C;
        wr_en    = rx_valid && (op == OP_WRITE);
        // A read is taken if the tx slot is free or is being emptied at this edge.
        rd_fire  = rx_valid && (op == OP_READ) && (!tx_valid || tx_ready);
        rd_drop  = rx_valid && (op == OP_READ) && tx_valid && !tx_ready;
        set_err  = rx_valid && ((op == OP_SET_WR) || (op == OP_SET_RD)) && !addr_ok;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= pay_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr <= '0;
            rd_addr <= '0;
        end else if (rx_valid) begin
            case (op)
                OP_SET_WR: if (addr_ok) wr_addr <= pay_addr;
                OP_WRITE:  if (AUTO_INC != 0) wr_addr <= bump(wr_addr);
                OP_SET_RD: if (addr_ok) rd_addr <= pay_addr;
                OP_READ:   if (rd_fire && (AUTO_INC != 0)) rd_addr <= bump(rd_addr);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data  <= '0;
            tx_valid <= 1'b0;
        end else if (rd_fire) begin
            tx_data  <= mem[rd_addr];
            tx_valid <= 1'b1;
        end else if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
        end
    end

    // Set has priority over clear when both happen at the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_err <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            addr_err <= (addr_err && !err_clr) || set_err;
            overrun  <= (overrun && !err_clr) || rd_drop;
        end
    end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Self-checking bench: two DUTs (auto-increment on/off) share one stimulus stream
// and are compared every cycle against an array-based behavioural model.
module tb_spi_ram_ctrl;

    localparam int DEPTH = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_valid = 1'b0;
    logic [9:0] rx_data = '0;
    logic       tx_ready = 1'b1;
    logic       err_clr = 1'b0;

    logic [7:0] a_tx_data, b_tx_data;
    logic       a_tx_valid, b_tx_valid, a_addr_err, b_addr_err, a_overrun, b_overrun;

    int passed = 0;
    int total  = 0;
    bit chk_on = 0;

    // Behavioural model state, index 0 = AUTO_INC=1 DUT, index 1 = AUTO_INC=0 DUT.
    logic [7:0] m_mem [2][DEPTH];
    int         m_wr   [2];
    int         m_rd   [2];
    logic       m_txv  [2];
    logic [7:0] m_txd  [2];
    logic       m_aerr [2];
    logic       m_ovr  [2];

    spi_ram_ctrl #(.MEM_DEPTH(DEPTH), .DATA_W(8), .AUTO_INC(1)) dut_a (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(tx_ready),
        .err_clr(err_clr), .addr_err(a_addr_err), .overrun(a_overrun)
    );

    spi_ram_ctrl #(.MEM_DEPTH(DEPTH), .DATA_W(8), .AUTO_INC(0)) dut_b (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(tx_ready),
        .err_clr(err_clr), .addr_err(b_addr_err), .overrun(b_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    // Model: applies the command rules to plain arrays at each rising edge.
    initial forever begin
        @(posedge clk or posedge rst);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_wr[k] = 0; m_rd[k] = 0; m_txv[k] = 0; m_txd[k] = '0;
                m_aerr[k] = 0; m_ovr[k] = 0;
            end else begin
                automatic logic       old_v = m_txv[k];
                automatic logic [1:0] op    = rx_data[9:8];
                automatic int         pay   = int'(rx_data[7:0]);
                automatic bit         inc   = (k == 0);
                if (old_v && tx_ready) m_txv[k] = 0;
                if (err_clr) begin m_aerr[k] = 0; m_ovr[k] = 0; end
                if (rx_valid) begin
                    case (op)
                        2'd0: if (pay < DEPTH) m_wr[k] = pay; else m_aerr[k] = 1;
                        2'd1: begin
                            m_mem[k][m_wr[k]] = pay[7:0];
                            if (inc) m_wr[k] = (m_wr[k] + 1) % DEPTH;
                        end
                        2'd2: if (pay < DEPTH) m_rd[k] = pay; else m_aerr[k] = 1;
                        default: begin
                            if (!old_v || tx_ready) begin
                                m_txd[k] = m_mem[k][m_rd[k]];
                                m_txv[k] = 1;
                                if (inc) m_rd[k] = (m_rd[k] + 1) % DEPTH;
                            end else begin
                                m_ovr[k] = 1;
                            end
                        end
                    endcase
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            check("a_tx_valid", a_tx_valid, m_txv[0]);
            check("a_tx_data",  a_tx_data,  m_txd[0]);
            check("a_addr_err", a_addr_err, m_aerr[0]);
            check("a_overrun",  a_overrun,  m_ovr[0]);
            check("b_tx_valid", b_tx_valid, m_txv[1]);
            check("b_tx_data",  b_tx_data,  m_txd[1]);
            check("b_addr_err", b_addr_err, m_aerr[1]);
            check("b_overrun",  b_overrun,  m_ovr[1]);
        end
    end

    task automatic cmd(input logic [1:0] op, input logic [7:0] pay);
        rx_valid = 1'b1;
        rx_data  = {op, pay};
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_data  = 10'($urandom);
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_on = 1;
        check("reset_tx_valid", a_tx_valid, 0);
        check("reset_tx_data",  a_tx_data,  0);
        check("reset_addr_err", a_addr_err, 0);
        check("reset_overrun",  a_overrun,  0);

        // Preload every word with a known pattern (i*3+1).
        for (int i = 0; i < DEPTH; i++) begin
            cmd(2'd0, 8'(i));
            cmd(2'd1, 8'(i * 3 + 1));
        end

        // Reset in the middle of traffic with every output non-zero.
        tx_ready = 1'b0;
        cmd(2'd2, 8'd5);
        cmd(2'd3, 8'd0);
        check("pre_rst_tx_data", a_tx_data, 8'h10);
        cmd(2'd3, 8'd0);
        cmd(2'd0, 8'd250);
        check("pre_rst_flags", {a_tx_valid, a_overrun, a_addr_err}, 3'b111);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_tx_valid", a_tx_valid, 0);
        check("mid_rst_tx_data",  a_tx_data,  0);
        check("mid_rst_addr_err", a_addr_err, 0);
        check("mid_rst_overrun",  a_overrun,  0);
        @(posedge clk); #1 rst = 1'b0;
        tx_ready = 1'b1;
        cmd(2'd1, 8'h11);
        cmd(2'd3, 8'd0);
        check("post_rst_read", {a_tx_valid, a_tx_data}, {1'b1, 8'h11});

        // Back-to-back burst.
        cmd(2'd0, 8'h10);
        cmd(2'd1, 8'hA1); cmd(2'd1, 8'hB2); cmd(2'd1, 8'hC3);
        cmd(2'd2, 8'h10);
        cmd(2'd3, 8'd0); check("burst0", {a_tx_valid, a_tx_data}, {1'b1, 8'hA1});
        cmd(2'd3, 8'd0); check("burst1", {a_tx_valid, a_tx_data}, {1'b1, 8'hB2});
        cmd(2'd3, 8'd0); check("burst2", {a_tx_valid, a_tx_data}, {1'b1, 8'hC3});
        idle();          check("burst_end_valid", a_tx_valid, 0);

        // Wrap at the last address.
        cmd(2'd0, 8'd199);
        cmd(2'd1, 8'h5A); cmd(2'd1, 8'h6B);
        cmd(2'd2, 8'd199);
        cmd(2'd3, 8'd0); check("wrap0", a_tx_data, 8'h5A);
        cmd(2'd3, 8'd0); check("wrap1", a_tx_data, 8'h6B);
        cmd(2'd3, 8'd0); check("wrap_rd_is_1", a_tx_data, 8'h04);

        // Out-of-range address and err_clr priority.
        cmd(2'd0, 8'd10);
        cmd(2'd0, 8'd200); check("range_err_set", a_addr_err, 1);
        cmd(2'd1, 8'h77);
        cmd(2'd2, 8'd10);
        cmd(2'd3, 8'd0);   check("range_wr_kept", a_tx_data, 8'h77);
        err_clr = 1'b1; idle(); err_clr = 1'b0;
        check("err_clr", a_addr_err, 0);
        err_clr = 1'b1; cmd(2'd2, 8'd255); err_clr = 1'b0;
        check("set_beats_clr", a_addr_err, 1);
        err_clr = 1'b1; idle(); err_clr = 1'b0;

        // Backpressure and overrun.
        idle();
        tx_ready = 1'b0;
        cmd(2'd2, 8'd0);
        cmd(2'd3, 8'd0); check("bp_first", {a_tx_valid, a_tx_data}, {1'b1, 8'h6B});
        cmd(2'd3, 8'd0); check("bp_drop", {a_tx_valid, a_overrun, a_tx_data}, {2'b11, 8'h6B});
        tx_ready = 1'b1;
        idle();          check("bp_accept", a_tx_valid, 0);
        cmd(2'd3, 8'd0); check("bp_rd_once", a_tx_data, 8'h04);
        err_clr = 1'b1; idle(); err_clr = 1'b0;

        // Fixed-address behaviour of the AUTO_INC=0 instance.
        cmd(2'd0, 8'd5);
        cmd(2'd1, 8'h01); cmd(2'd1, 8'h02);
        cmd(2'd2, 8'd5);
        cmd(2'd3, 8'd0); check("noinc_rd0", b_tx_data, 8'h02);
        cmd(2'd3, 8'd0); check("noinc_rd1", b_tx_data, 8'h02);

        // Random traffic including out-of-range payloads, stalls and clears.
        repeat (3000) begin
            rx_valid = ($urandom % 4) != 0;
            rx_data  = 10'($urandom);
            tx_ready = ($urandom % 3) != 0;
            err_clr  = ($urandom % 16) == 0;
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        err_clr  = 1'b0;
        tx_ready = 1'b1;
        repeat (3) idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
